// File: rtl/filter_pkg.sv
// Shared constants and state encoding for the sample capture / filter datapath.
// Sizes here set the defaults of the receive-side sample assembler.
package filter_pkg;

  localparam int SAMPLE_W      = 16;
  localparam int SAMPLE_ADDR_W = 14;
  localparam int NUM_SAMPLES   = 16384;
  localparam int CLK_HZ        = 50_000_000;

  typedef enum logic [1:0] {
    ASM_IDLE    = 2'd0,
    ASM_COLLECT = 2'd1,
    ASM_DONE    = 2'd2
  } asm_state_t;

endpackage

// File: rtl/uart_sample_assembler_rx_idle_timer.sv
// Idle-gap counter: expires on the TIMEOUT_CYCLES-th consecutive enabled cycle,
// then restarts from zero on its own.
module rx_idle_timer #(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expire
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] r_count;

  assign o_expire = i_enable && (r_count == LAST_CNT);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of block ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_clear || o_expire) begin
      r_count <= '0;
    end else if (i_enable) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/uart_sample_assembler.sv
// Packs UART receive bytes MSB-first into sample words and streams them into
// the sample RAM write port with an auto-incrementing address.
module uart_sample_assembler
  import filter_pkg::*;
#(
  parameter int BYTES_PER_WORD = SAMPLE_W / 8,
  parameter int ADDR_W         = SAMPLE_ADDR_W,
  parameter int NUM_WORDS      = NUM_SAMPLES,
  parameter int TIMEOUT_CYCLES = CLK_HZ / 1000
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic [7:0]                  rx_data,
  input  logic                        rx_valid,
  input  logic                        rx_err,
  output logic                        wr_en,
  output logic [ADDR_W-1:0]           wr_addr,
  output logic [8*BYTES_PER_WORD-1:0] wr_data,
  output logic                        busy,
  output logic                        done,
  output logic                        frame_err,
  output logic [ADDR_W:0]             word_count
);

  localparam int WORD_W = 8 * BYTES_PER_WORD;
  localparam int IDX_W  = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(BYTES_PER_WORD - 1);
  localparam logic [ADDR_W:0]  LAST_WORD = (ADDR_W + 1)'(NUM_WORDS - 1);

  asm_state_t         r_state;
  logic [WORD_W-1:0]  r_shreg;
  logic [IDX_W-1:0]   r_byte_idx;
  logic               r_wr_en;
  logic [ADDR_W-1:0]  r_wr_addr;
  logic [ADDR_W:0]    r_word_count;
  logic               r_frame_err;

  logic w_timer_en;
  logic w_timer_clr;
  logic w_expire;

  // The idle counter only sees gaps inside a partial word; any byte restarts it.
  assign w_timer_en  = (r_state == ASM_COLLECT) && (r_byte_idx != '0) && !rx_valid;
  assign w_timer_clr = !w_timer_en;

  rx_idle_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_idle_timer (
    .clk     (clk),
    .reset   (reset),
    .i_clear (w_timer_clr),
    .i_enable(w_timer_en),
    .o_expire(w_expire)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ASM_IDLE;
      r_shreg      <= '0;
      r_byte_idx   <= '0;
      r_wr_en      <= 1'b0;
      r_wr_addr    <= '0;
      r_word_count <= '0;
      r_frame_err  <= 1'b0;
    end else begin
      // NOTE: wr_en defaults low every cycle so a completed word pulses it once.
      r_wr_en <= 1'b0;
      case (r_state)
        ASM_IDLE, ASM_DONE: begin
          if (start) begin
            r_state      <= ASM_COLLECT;
            r_byte_idx   <= '0;
            r_wr_addr    <= '0;
            r_word_count <= '0;
            r_frame_err  <= 1'b0;
          end
        end
        ASM_COLLECT: begin
          // Address bookkeeping trails the write strobe by one cycle.
          if (r_wr_en) begin
            r_word_count <= r_word_count + (ADDR_W + 1)'(1);
            if (r_word_count == LAST_WORD) begin
              r_state   <= ASM_DONE;
              r_wr_addr <= '0;
            end else begin
              r_wr_addr <= r_wr_addr + ADDR_W'(1);
            end
          end
          if (rx_valid) begin
            if (rx_err) begin
              r_byte_idx  <= '0;
              r_frame_err <= 1'b1;
            end else begin
              r_shreg <= {r_shreg[WORD_W-9:0], rx_data};
              if (r_byte_idx == LAST_IDX) begin
                r_byte_idx <= '0;
                r_wr_en    <= 1'b1;
              end else begin
                r_byte_idx <= r_byte_idx + IDX_W'(1);
              end
            end
          end else if (w_expire) begin
            r_byte_idx  <= '0;
            r_frame_err <= 1'b1;
          end
        end
        default: r_state <= ASM_IDLE;
      endcase
    end
  end

  // The shift register holds the completed word throughout the wr_en cycle.
  assign wr_en      = r_wr_en;
  assign wr_addr    = r_wr_addr;
  assign wr_data    = r_shreg;
  assign busy       = (r_state == ASM_COLLECT);
  assign done       = (r_state == ASM_DONE);
  assign frame_err  = r_frame_err;
  assign word_count = r_word_count;

endmodule

// File: tb/tb_uart_sample_assembler.sv
// Directed bench for uart_sample_assembler with a short capture and timeout.
module tb_uart_sample_assembler;

  localparam int NW = 4;
  localparam int TO = 20;
  localparam int AW = 14;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic          rx_valid = 1'b0;
  logic          rx_err = 1'b0;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [15:0]   wr_data;
  logic          busy;
  logic          done;
  logic          frame_err;
  logic [AW:0]   word_count;

  int   n_vec = 0;
  int   n_err = 0;
  int   wr_runs = 0;
  logic prev_wr = 1'b0;
  logic [29:0] wlog[$];

  uart_sample_assembler #(
    .BYTES_PER_WORD(2),
    .ADDR_W        (AW),
    .NUM_WORDS     (NW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_err    (rx_err),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .busy      (busy),
    .done      (done),
    .frame_err (frame_err),
    .word_count(word_count)
  );

  always #5 clk = ~clk;

  // Write log, sampled mid-cycle; also flags any back-to-back wr_en.
  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      wlog.push_back({wr_addr, wr_data});
      if (prev_wr) wr_runs++;
    end
    prev_wr = (wr_en === 1'b1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %-16s got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_wr(input string tag, input int idx, input logic [13:0] a,
                          input logic [15:0] d);
    check(tag, (idx < wlog.size()) ? {2'b00, wlog[idx]} : 32'hFFFF_FFFF, {2'b00, a, d});
  endtask

  task automatic put(input logic [7:0] d, input logic e = 1'b0);
    rx_data  = d;
    rx_err   = e;
    rx_valid = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    rx_valid = 1'b0;
    rx_err   = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
    end
    reset = 1'b0;
    wlog.delete();
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog    simulation did not reach the summary in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    @(posedge clk); #1;
    check("rst_ctl", {wr_en, busy, done, frame_err}, 4'b0000);
    check("rst_addr", {wr_addr, word_count}, 0);
    check("rst_data", wr_data, 16'h0000);
    reset = 1'b0;
    wlog.delete();

    // Bytes in IDLE are ignored
    put(8'h99); put(8'h98); idle(2);
    check("idle_ign_n", wlog.size(), 0);
    check("idle_busy", busy, 1'b0);

    // Start with a simultaneous byte, then 0x12, gap, 0x34
    start = 1'b1; rx_data = 8'hEE; rx_valid = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; rx_valid = 1'b0;
    check("t1_busy", busy, 1'b1);
    put(8'h12); idle(0);
    check("t1_wr_early", wr_en, 1'b0);
    idle(2);
    put(8'h34); idle(0);
    check("t1_wr_en", wr_en, 1'b1);
    check("t1_addr", wr_addr, 0);
    check("t1_data", wr_data, 16'h1234);
    check("t1_wc_pre", word_count, 0);
    idle(1);
    check("t1_wr_off", wr_en, 1'b0);
    check("t1_wc", word_count, 1);
    check("t1_addr_inc", wr_addr, 1);
    check("t1_n", wlog.size(), 1);

    // Back-to-back bytes
    do_reset(); do_start();
    put(8'hAA); put(8'hBB); put(8'hCC); put(8'hDD); idle(0);
    check("t2_busy", busy, 1'b1);
    idle(2);
    check("t2_n", wlog.size(), 2);
    check_wr("t2_w0", 0, 14'd0, 16'hAABB);
    check_wr("t2_w1", 1, 14'd1, 16'hCCDD);
    check("t2_wc", word_count, 2);
    do_start();
    check("t2_start_ign", {busy, word_count}, {1'b1, 15'd2});

    // Gap one short of the timeout keeps the word
    do_reset(); do_start();
    put(8'h56); idle(TO - 1); put(8'h78); idle(2);
    check("t3a_ferr", frame_err, 1'b0);
    check("t3a_n", wlog.size(), 1);
    check_wr("t3a_w0", 0, 14'd0, 16'h5678);

    // Full timeout discards the partial byte
    do_reset(); do_start();
    put(8'h56); idle(TO);
    check("t3b_ferr", frame_err, 1'b1);
    put(8'h9A); put(8'hBC); idle(2);
    check("t3b_n", wlog.size(), 1);
    check_wr("t3b_w0", 0, 14'd0, 16'h9ABC);

    // Framing errors
    do_reset(); do_start();
    put(8'h11, 1'b1); idle(0);
    check("t4_ferr", frame_err, 1'b1);
    put(8'h22); put(8'h33); idle(2);
    put(8'h55); put(8'h5A, 1'b1); put(8'h66); put(8'h77); idle(2);
    check("t4_n", wlog.size(), 2);
    check_wr("t4_w0", 0, 14'd0, 16'h2233);
    check_wr("t4_w1", 1, 14'd1, 16'h6677);

    // Full capture of NW words, DONE, re-arm
    do_reset(); do_start();
    for (int i = 1; i <= 8; i++) put(8'(i));
    idle(0);
    check("t5_last_wr", {wr_en, busy, done}, 3'b110);
    idle(1);
    check("t5_done", {busy, done}, 2'b01);
    check("t5_wc", word_count, NW);
    check("t5_addr_wrap", wr_addr, 0);
    put(8'hC1); put(8'hC2); idle(2);
    check("t5_n", wlog.size(), NW);
    for (int k = 0; k < NW; k++)
      check_wr($sformatf("t5_w%0d", k), k, 14'(k), {8'(2*k+1), 8'(2*k+2)});
    do_start();
    check("t5_rearm", {busy, done}, 2'b10);
    check("t5_rearm_wc", word_count, 0);
    put(8'hA1); put(8'hA2); idle(2);
    check("t5_n2", wlog.size(), NW + 1);
    check_wr("t5_w4", NW, 14'd0, 16'hA1A2);

    // Asynchronous reset mid-word
    do_reset(); do_start();
    put(8'h01); put(8'h02); idle(2);
    check("t6_wc_pre", word_count, 1);
    put(8'hDE); idle(0);
    #3 reset = 1'b1;
    #1;
    check("t6_rst_ctl", {wr_en, busy, done, frame_err}, 4'b0000);
    check("t6_rst_addr", {wr_addr, word_count}, 0);
    check("t6_rst_data", wr_data, 16'h0000);
    @(posedge clk); #1;
    reset = 1'b0;
    wlog.delete();
    idle(2);
    check("t6_no_wr", wlog.size(), 0);
    do_start();
    put(8'hDE); put(8'hAD); idle(2);
    check("t6_n", wlog.size(), 1);
    check_wr("t6_w0", 0, 14'd0, 16'hDEAD);

    check("wr_en_runs", wr_runs, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
